v_pipe_update: RTL

- Write-side counterpart of the list query pipeline: the 5-stage pipeline that applies update commands to the per-product state table.
- Each command is a read-modify-write of one table row, addressed by product ID.
- Publishes stage valid/ID pairs (S1..S4) so the query pipeline can detect in-flight updates.
- Produces one response per command, reporting success or error.

---
 rtl/v_pipe_update_if.sv | 53 +++++
 rtl/v_pipe_update.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/v_pipe_update_if.sv
// Command, response, state-table and stage-visibility signals of the update pipeline.
// slave is the pipeline side; master is the command source and table owner.
interface v_pipe_update_if #(
    parameter int ENTRIES_N = 16,
    parameter int ID_W      = 8,
    parameter int KEY_W     = 16,
    parameter int VOL_W     = 16
);
    localparam int LS_W    = $clog2(ENTRIES_N + 1);
    localparam int LVL_W   = $clog2(ENTRIES_N);
    localparam int STATE_W = ENTRIES_N * (1 + KEY_W + VOL_W) + LS_W;

    logic               i_upd_vld;
    logic [ID_W-1:0]    i_upd_prod_id;
    logic [1:0]         i_upd_cmd;
    logic [LVL_W-1:0]   i_upd_level;
    logic [KEY_W-1:0]   i_upd_key;
    logic [VOL_W-1:0]   i_upd_size;
    logic               o_upd_vld_r;
    logic               o_upd_error_r;
    logic               o_state_ren;
    logic [ID_W-1:0]    o_state_raddr;
    logic [STATE_W-1:0] i_state_rdata;
    logic               o_state_wen;
    logic [ID_W-1:0]    o_state_waddr;
    logic [STATE_W-1:0] o_state_wdata;
    logic               o_s1_upd_vld_r;
    logic [ID_W-1:0]    o_s1_upd_prod_id_r;
    logic               o_s2_upd_vld_r;
    logic [ID_W-1:0]    o_s2_upd_prod_id_r;
    logic               o_s3_upd_vld_r;
    logic [ID_W-1:0]    o_s3_upd_prod_id_r;
    logic               o_s4_upd_vld_r;
    logic [ID_W-1:0]    o_s4_upd_prod_id_r;

    modport master (
        output i_upd_vld, i_upd_prod_id, i_upd_cmd, i_upd_level, i_upd_key, i_upd_size,
        output i_state_rdata,
        input  o_upd_vld_r, o_upd_error_r, o_state_ren, o_state_raddr,
        input  o_state_wen, o_state_waddr, o_state_wdata,
        input  o_s1_upd_vld_r, o_s1_upd_prod_id_r, o_s2_upd_vld_r, o_s2_upd_prod_id_r,
        input  o_s3_upd_vld_r, o_s3_upd_prod_id_r, o_s4_upd_vld_r, o_s4_upd_prod_id_r
    );

    modport slave (
        input  i_upd_vld, i_upd_prod_id, i_upd_cmd, i_upd_level, i_upd_key, i_upd_size,
        input  i_state_rdata,
        output o_upd_vld_r, o_upd_error_r, o_state_ren, o_state_raddr,
        output o_state_wen, o_state_waddr, o_state_wdata,
        output o_s1_upd_vld_r, o_s1_upd_prod_id_r, o_s2_upd_vld_r, o_s2_upd_prod_id_r,
        output o_s3_upd_vld_r, o_s3_upd_prod_id_r, o_s4_upd_vld_r, o_s4_upd_prod_id_r
    );
endinterface

// File: rtl/v_pipe_update.sv
// Five-stage read-modify-write pipeline applying update commands to the per-product state table.
// Forwarding from S2..S5 makes back-to-back commands on one ID behave as if executed in order.
module v_pipe_update #(
    parameter int ENTRIES_N = 16,
    parameter int ID_W      = 8,
    parameter int KEY_W     = 16,
    parameter int VOL_W     = 16
) (
    input  logic           clk,
    input  logic           rst,
    v_pipe_update_if.slave bus
);
    localparam int LS_W  = $clog2(ENTRIES_N + 1);
    localparam int LVL_W = $clog2(ENTRIES_N);

    localparam logic [1:0] CMD_CLEAR  = 2'd0;
    localparam logic [1:0] CMD_ADD    = 2'd1;
    localparam logic [1:0] CMD_DELETE = 2'd2;

    typedef struct packed {
        logic [LS_W-1:0]                 listsize;
        logic [ENTRIES_N-1:0]            vld;
        logic [ENTRIES_N-1:0][KEY_W-1:0] key;
        logic [ENTRIES_N-1:0][VOL_W-1:0] vol;
    } row_t;

    logic [4:1]       stg_vld_reg;
    logic [ID_W-1:0]  stg_id_reg [1:4];

    logic [1:0]       s1_cmd_reg;
    logic [LVL_W-1:0] s1_level_reg;
    logic [KEY_W-1:0] s1_key_reg;
    logic [VOL_W-1:0] s1_size_reg;
    row_t             s1_old_next;

    logic [1:0]       s2_cmd_reg;
    logic [LVL_W-1:0] s2_level_reg;
    logic [KEY_W-1:0] s2_key_reg;
    logic [VOL_W-1:0] s2_size_reg;
    row_t             s2_old_reg;
    row_t             s2_new_next;
    logic             s2_err_next;
    logic             s2_old_v;
    logic [ENTRIES_N-1:0] lvl_hit;

    row_t             s3_row_reg;
    logic             s3_err_reg;
    row_t             s4_row_reg;
    logic             s4_err_reg;
    logic             s4_wen;

    logic             s5_vld_reg;
    logic [ID_W-1:0]  s5_id_reg;
    row_t             s5_row_reg;

    // Stage valids are the only reset state; data registers follow their valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_vld_reg <= '0;
            s5_vld_reg  <= 1'b0;
        end else begin
            stg_vld_reg <= {stg_vld_reg[3:1], bus.i_upd_vld};
            s5_vld_reg  <= s4_wen;
        end
    end

    always_ff @(posedge clk) begin
        if (bus.i_upd_vld) begin
            stg_id_reg[1] <= bus.i_upd_prod_id;
            s1_cmd_reg    <= bus.i_upd_cmd;
            s1_level_reg  <= bus.i_upd_level;
            s1_key_reg    <= bus.i_upd_key;
            s1_size_reg   <= bus.i_upd_size;
        end
        for (int i = 2; i <= 4; i++) begin
            if (stg_vld_reg[i-1]) begin
                stg_id_reg[i] <= stg_id_reg[i-1];
            end
        end
        if (stg_vld_reg[1]) begin
            s2_cmd_reg   <= s1_cmd_reg;
            s2_level_reg <= s1_level_reg;
            s2_key_reg   <= s1_key_reg;
            s2_size_reg  <= s1_size_reg;
            s2_old_reg   <= s1_old_next;
        end
        if (stg_vld_reg[2]) begin
            s3_row_reg <= s2_new_next;
            s3_err_reg <= s2_err_next;
        end
        if (stg_vld_reg[3]) begin
            s4_row_reg <= s3_row_reg;
            s4_err_reg <= s3_err_reg;
        end
        if (s4_wen) begin
            s5_id_reg  <= stg_id_reg[4];
            s5_row_reg <= s4_row_reg;
        end
    end

    // Youngest writing stage wins; erroring stages leave the row untouched so they are skipped.
    always_comb begin
        s1_old_next = bus.i_state_rdata;
        if (stg_vld_reg[2] && !s2_err_next && stg_id_reg[2] == stg_id_reg[1]) begin
            s1_old_next = s2_new_next;
        end else if (stg_vld_reg[3] && !s3_err_reg && stg_id_reg[3] == stg_id_reg[1]) begin
            s1_old_next = s3_row_reg;
        end else if (s4_wen && stg_id_reg[4] == stg_id_reg[1]) begin
            s1_old_next = s4_row_reg;
        end else if (s5_vld_reg && s5_id_reg == stg_id_reg[1]) begin
            s1_old_next = s5_row_reg;
        end
    end

    for (genvar gi = 0; gi < ENTRIES_N; gi++) begin : g_lvl_hit
        assign lvl_hit[gi] = (s2_level_reg == LVL_W'(gi));
    end

    always_comb begin
        s2_new_next = s2_old_reg;
        s2_err_next = 1'b0;
        s2_old_v    = |(s2_old_reg.vld & lvl_hit);
        case (s2_cmd_reg)
            CMD_CLEAR: begin
                s2_new_next.vld      = '0;
                s2_new_next.listsize = '0;
            end
            CMD_ADD: begin
                if (s2_old_v) begin
                    s2_err_next = 1'b1;
                end else begin
                    s2_new_next.vld               = s2_old_reg.vld | lvl_hit;
                    s2_new_next.key[s2_level_reg] = s2_key_reg;
                    s2_new_next.vol[s2_level_reg] = s2_size_reg;
                    s2_new_next.listsize          = s2_old_reg.listsize + LS_W'(1);
                end
            end
            CMD_DELETE: begin
                if (!s2_old_v) begin
                    s2_err_next = 1'b1;
                end else begin
                    s2_new_next.vld      = s2_old_reg.vld & ~lvl_hit;
                    s2_new_next.listsize = s2_old_reg.listsize - LS_W'(1);
                end
            end
            default: begin
                if (!s2_old_v) begin
                    s2_err_next = 1'b1;
                end else begin
                    s2_new_next.key[s2_level_reg] = s2_key_reg;
                    s2_new_next.vol[s2_level_reg] = s2_size_reg;
                end
            end
        endcase
    end

    assign s4_wen = stg_vld_reg[4] & ~s4_err_reg;

    assign bus.o_state_ren        = bus.i_upd_vld;
    assign bus.o_state_raddr      = bus.i_upd_prod_id;
    assign bus.o_state_wen        = s4_wen;
    assign bus.o_state_waddr      = stg_id_reg[4];
    assign bus.o_state_wdata      = s4_row_reg;
    assign bus.o_upd_vld_r        = stg_vld_reg[4];
    assign bus.o_upd_error_r      = stg_vld_reg[4] & s4_err_reg;
    assign bus.o_s1_upd_vld_r     = stg_vld_reg[1];
    assign bus.o_s1_upd_prod_id_r = stg_id_reg[1];
    assign bus.o_s2_upd_vld_r     = stg_vld_reg[2];
    assign bus.o_s2_upd_prod_id_r = stg_id_reg[2];
    assign bus.o_s3_upd_vld_r     = stg_vld_reg[3];
    assign bus.o_s3_upd_prod_id_r = stg_id_reg[3];
    assign bus.o_s4_upd_vld_r     = stg_vld_reg[4];
    assign bus.o_s4_upd_prod_id_r = stg_id_reg[4];
endmodule
